// File: rtl/qif_pkg.sv
// Shared types and constants for the QIF neuron and its spike decoder.
package qif_pkg;

    typedef logic signed [7:0] volt_t;

    localparam volt_t QIF_VPEAK      = 8'sd50;
    localparam volt_t QIF_VRESET     = -8'sd20;
    localparam volt_t QIF_THRESH_DEF = 8'sd40;
    localparam volt_t QIF_REARM_DEF  = 8'sd0;

    localparam logic [0:0] DET_ARMED = 1'b0;
    localparam logic [0:0] DET_FIRED = 1'b1;

endpackage

// File: rtl/qif_isi_fifo.sv
// First-word-fall-through FIFO for ISI values; counts pushes dropped while full.
module qif_isi_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] head,
    output logic             head_valid,
    output logic [7:0]       drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             valid_q, valid_d;
    logic [7:0]       drop_q, drop_d;
    logic             pop_c;
    logic             full_c;
    logic             do_push_c;

    // A pop frees the slot a same-cycle push needs, so push-while-full-with-pop succeeds.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        drop_d    = drop_q;
        pop_c     = valid_q && pop_ready;
        full_c    = (count_q == CW'(DEPTH));
        do_push_c = push && (!full_c || pop_c);

        if (push && full_c && !pop_c && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
        if (do_push_c) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(do_push_c) - CW'(pop_c);
        valid_d = (count_d != '0);
        head_d  = valid_d ? mem_d[rd_ptr_d] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
            drop_q   <= 8'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
            drop_q   <= drop_d;
        end
    end

    assign head       = head_q;
    assign head_valid = valid_q;
    assign drop_cnt   = drop_q;

endmodule

// File: rtl/qif_spike_decoder.sv
// Spike detector with hysteresis, inter-spike-interval measurement and windowed rate count.
module qif_spike_decoder
    import qif_pkg::*;
#(
    parameter volt_t       THRESH     = QIF_THRESH_DEF,
    parameter volt_t       REARM      = QIF_REARM_DEF,
    parameter int unsigned ISI_W      = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WIN_LOG2   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          v_in,
    input  logic                v_valid,
    output logic                spike,
    output logic [ISI_W-1:0]    isi_data,
    output logic                isi_valid,
    input  logic                isi_ready,
    output logic [7:0]          drop_cnt,
    output logic [WIN_LOG2:0]   rate,
    output logic                rate_valid
);

    localparam int unsigned RW = WIN_LOG2 + 1;
    localparam logic [ISI_W-1:0] ISI_MAX = '1;

    volt_t               v_s;
    logic [0:0]          state_q, state_d;
    logic                spike_q, spike_d;
    logic                have_prev_q, have_prev_d;
    logic [ISI_W-1:0]    isi_cnt_q, isi_cnt_d;
    logic [WIN_LOG2-1:0] win_cnt_q, win_cnt_d;
    logic [RW-1:0]       win_spk_q, win_spk_d;
    logic [RW-1:0]       rate_q, rate_d;
    logic                rate_valid_q, rate_valid_d;
    logic                spike_now_c;
    logic                push_c;
    logic [ISI_W-1:0]    isi_inc_c;
    logic [RW-1:0]       spk_total_c;

    assign v_s = volt_t'(v_in);

    // isi_inc_c is the interval ending at the current sample, saturated.
    always_comb begin
        state_d      = state_q;
        spike_d      = 1'b0;
        have_prev_d  = have_prev_q;
        isi_cnt_d    = isi_cnt_q;
        win_cnt_d    = win_cnt_q;
        win_spk_d    = win_spk_q;
        rate_d       = rate_q;
        rate_valid_d = 1'b0;
        spike_now_c  = 1'b0;
        push_c       = 1'b0;
        isi_inc_c    = (isi_cnt_q == ISI_MAX) ? ISI_MAX : isi_cnt_q + ISI_W'(1);
        spk_total_c  = win_spk_q;

        if (v_valid) begin
            case (state_q)
                DET_ARMED: begin
                    if (v_s >= THRESH) begin
                        spike_now_c = 1'b1;
                        state_d     = DET_FIRED;
                    end
                end
                DET_FIRED: begin
                    if (v_s <= REARM) begin
                        state_d = DET_ARMED;
                    end
                end
                default: state_d = DET_ARMED;
            endcase

            spike_d = spike_now_c;
            if (spike_now_c) begin
                push_c      = have_prev_q;
                have_prev_d = 1'b1;
                isi_cnt_d   = '0;
            end else if (have_prev_q) begin
                isi_cnt_d = isi_inc_c;
            end

            spk_total_c = win_spk_q + RW'(spike_now_c);
            win_cnt_d   = win_cnt_q + WIN_LOG2'(1);
            if (win_cnt_q == '1) begin
                rate_d       = spk_total_c;
                rate_valid_d = 1'b1;
                win_spk_d    = '0;
            end else begin
                win_spk_d = spk_total_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= DET_ARMED;
            spike_q      <= 1'b0;
            have_prev_q  <= 1'b0;
            isi_cnt_q    <= '0;
            win_cnt_q    <= '0;
            win_spk_q    <= '0;
            rate_q       <= '0;
            rate_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            spike_q      <= spike_d;
            have_prev_q  <= have_prev_d;
            isi_cnt_q    <= isi_cnt_d;
            win_cnt_q    <= win_cnt_d;
            win_spk_q    <= win_spk_d;
            rate_q       <= rate_d;
            rate_valid_q <= rate_valid_d;
        end
    end

    qif_isi_fifo #(
        .WIDTH (ISI_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_c),
        .push_data  (isi_inc_c),
        .pop_ready  (isi_ready),
        .head       (isi_data),
        .head_valid (isi_valid),
        .drop_cnt   (drop_cnt)
    );

    assign spike      = spike_q;
    assign rate       = rate_q;
    assign rate_valid = rate_valid_q;

endmodule

// File: tb/tb_qif_spike_decoder.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_qif_spike_decoder;

    localparam int ISI_W    = 4;
    localparam int WIN_LOG2 = 4;
    localparam int ISI_MAX  = (1 << ISI_W) - 1;
    localparam int WIN_LEN  = 1 << WIN_LOG2;
    localparam int DEPTH    = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [7:0]          v_in = 8'd0;
    logic                v_valid = 1'b0;
    logic                isi_ready = 1'b0;
    logic                spike;
    logic [ISI_W-1:0]    isi_data;
    logic                isi_valid;
    logic [7:0]          drop_cnt;
    logic [WIN_LOG2:0]   rate;
    logic                rate_valid;

    qif_spike_decoder #(
        .THRESH     (8'sd40),
        .REARM      (8'sd0),
        .ISI_W      (ISI_W),
        .FIFO_DEPTH (DEPTH),
        .WIN_LOG2   (WIN_LOG2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .v_in       (v_in),
        .v_valid    (v_valid),
        .spike      (spike),
        .isi_data   (isi_data),
        .isi_valid  (isi_valid),
        .isi_ready  (isi_ready),
        .drop_cnt   (drop_cnt),
        .rate       (rate),
        .rate_valid (rate_valid)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: sample indices, not counters.
    bit m_armed;
    int m_last;
    int m_idx;
    int m_win;
    int m_rate;
    bit m_rate_valid;
    int m_drop;
    int m_q[$];

    // Observations taken from DUT outputs for directed scenario totals.
    int obs_spikes;
    int obs_pops;
    int obs_rv;

    int hyst_seq[8] = '{-20, 10, 45, 60, 30, 45, -5, 41};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_armed = 1'b1;
        m_last = -1;
        m_idx = 0;
        m_win = 0;
        m_rate = 0;
        m_rate_valid = 1'b0;
        m_drop = 0;
        m_q.delete();
    endtask

    task automatic step(input int v, input logic vv, input logic rdy);
        logic [7:0] vb;
        int sv;
        int isi;
        bit spk;
        bit pop;
        vb = 8'(v);
        sv = $signed(vb);
        v_in = vb;
        v_valid = vv;
        isi_ready = rdy;
        if (isi_valid && rdy) obs_pops++;
        @(posedge clk);
        spk = 1'b0;
        pop = (m_q.size() != 0) && rdy;
        if (pop) void'(m_q.pop_front());
        m_rate_valid = 1'b0;
        if (vv) begin
            if (m_armed && sv >= 40) begin
                spk = 1'b1;
                m_armed = 1'b0;
                if (m_last >= 0) begin
                    isi = m_idx - m_last;
                    if (isi > ISI_MAX) isi = ISI_MAX;
                    if (m_q.size() < DEPTH) m_q.push_back(isi);
                    else if (m_drop < 255) m_drop++;
                end
                m_last = m_idx;
            end else if (!m_armed && sv <= 0) begin
                m_armed = 1'b1;
            end
            m_win += int'(spk);
            if ((m_idx % WIN_LEN) == WIN_LEN - 1) begin
                m_rate = m_win;
                m_rate_valid = 1'b1;
                m_win = 0;
            end
            m_idx++;
        end
        #1;
        chk("spike", 32'(spike), 32'(spk));
        chk("isi_valid", 32'(isi_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) chk("isi_data", 32'(isi_data), 32'(m_q[0]));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        chk("rate", 32'(rate), 32'(m_rate));
        chk("rate_valid", 32'(rate_valid), 32'(m_rate_valid));
        if (spike) obs_spikes++;
        if (rate_valid) obs_rv++;
    endtask

    // Assert reset between clock edges and check outputs clear without a clock.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_spike", 32'(spike), 32'd0);
        chk("rst_isi_valid", 32'(isi_valid), 32'd0);
        chk("rst_isi_data", 32'(isi_data), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_rate", 32'(rate), 32'd0);
        chk("rst_rate_valid", 32'(rate_valid), 32'd0);
        model_reset();
        v_valid = 1'b0;
        isi_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        obs_spikes = 0;
        obs_pops = 0;
        obs_rv = 0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Threshold and hysteresis
        foreach (hyst_seq[i]) step(hyst_seq[i], 1'b1, 1'b0);
        chk("hyst_spikes", 32'(obs_spikes), 32'd2);
        chk("hyst_isi_valid", 32'(isi_valid), 32'd1);
        chk("hyst_isi", 32'(isi_data), 32'd5);

        // Signed compare
        do_reset();
        step(8'hC8, 1'b1, 1'b0);
        chk("signed_neg", 32'(spike), 32'd0);
        step(8'h32, 1'b1, 1'b0);
        chk("signed_pos", 32'(spike), 32'd1);

        // FIFO full and drops, then drain
        do_reset();
        for (int k = 0; k < 6; k++) begin
            step(45, 1'b1, 1'b0);
            step(-5, 1'b1, 1'b0);
            step(-5, 1'b1, 1'b0);
        end
        chk("full_drop", 32'(drop_cnt), 32'd1);
        obs_pops = 0;
        for (int k = 0; k < 6; k++) step(0, 1'b0, 1'b1);
        chk("full_pops", 32'(obs_pops), 32'd4);
        chk("full_empty", 32'(isi_valid), 32'd0);

        // Simultaneous push and pop while full
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step(45, 1'b1, 1'b0);
            step(-5, 1'b1, 1'b0);
            step(-5, 1'b1, 1'b0);
        end
        step(45, 1'b1, 1'b1);
        chk("pp_drop", 32'(drop_cnt), 32'd0);
        obs_pops = 0;
        for (int k = 0; k < 6; k++) step(0, 1'b0, 1'b1);
        chk("pp_pops", 32'(obs_pops), 32'd4);

        // Rate window: spike every 4 samples, last one on sample 16
        do_reset();
        for (int k = 0; k < 2 * WIN_LEN; k++) step(((k % 4) == 3) ? 45 : -5, 1'b1, 1'b1);
        chk("rate_val", 32'(rate), 32'd4);
        chk("rate_pulses", 32'(obs_rv), 32'd2);

        // ISI saturation
        do_reset();
        step(45, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) step(-5, 1'b1, 1'b0);
        step(45, 1'b1, 1'b0);
        chk("isi_sat", 32'(isi_data), 32'(ISI_MAX));

        // Reset mid-stream with two queued ISIs
        do_reset();
        step(45, 1'b1, 1'b0);
        step(-5, 1'b1, 1'b0);
        step(-5, 1'b1, 1'b0);
        step(45, 1'b1, 1'b0);
        step(-5, 1'b1, 1'b0);
        step(45, 1'b1, 1'b0);
        step(-5, 1'b1, 1'b0);
        chk("mid_loaded", 32'(isi_valid), 32'd1);
        do_reset();
        step(45, 1'b1, 1'b0);
        chk("mid_first_spike", 32'(spike), 32'd1);
        chk("mid_no_isi", 32'(isi_valid), 32'd0);

        // Random traffic
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            step(int'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/qif_spike_decoder.md
Name: qif_spike_decoder

Overview:
- Receive-side companion to the QIF neuron. Samples the neuron's 8-bit signed membrane voltage and detects spikes with a threshold and a hysteresis re-arm level.
- Measures the inter-spike interval (ISI) and queues each ISI in a small FIFO behind a valid/ready handshake.
- Emits a windowed spike-rate count for downstream learning and readout logic.

Parameters:
- THRESH, 40, signed 8-bit spike threshold; a spike is detected when v_in >= THRESH while armed.
- REARM, 0, signed 8-bit re-arm level; the detector re-arms when v_in <= REARM. REARM must be < THRESH.
- ISI_W, 16, ISI width in samples; the ISI saturates at 2^ISI_W-1.
- FIFO_DEPTH, 4, ISI FIFO entries; must be a power of 2, >= 2.
- WIN_LOG2, 8, rate window of 2^WIN_LOG2 valid samples.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- v_in  in  8  neuron voltage, signed two's complement
- v_valid  in  1  v_in holds a new sample this cycle
- spike  out  1  one-cycle pulse per detected spike
- isi_data  out  ISI_W  head-of-FIFO ISI, in samples
- isi_valid  out  1  FIFO not empty
- isi_ready  in  1  consumer accepts isi_data
- drop_cnt  out  8  ISIs dropped because the FIFO was full; saturates at 255
- rate  out  WIN_LOG2+1  spikes in the last completed window
- rate_valid  out  1  one-cycle pulse when rate updates

Behaviour:
- Reset (rst_n low, asynchronous):
  - Outputs: spike=0, isi_valid=0, isi_data=0, drop_cnt=0, rate=0, rate_valid=0.
  - Internal state: detector ARMED, no previous spike recorded, ISI counter=0, window counter=0, window spike count=0, FIFO empty.
  - Reset asserted mid-operation discards FIFO contents and any partial window.
- Samples are processed only in cycles with v_valid=1. All comparisons against THRESH and REARM are signed.
- Detector FSM:
  - ARMED -> FIRED on a valid sample with v_in >= THRESH. This is a spike.
  - FIRED -> ARMED on a valid sample with v_in <= REARM.
  - No other transitions. A sample above threshold while FIRED is not a spike.
- spike is registered: it is high in the cycle after the clock edge that captured the crossing sample.
- ISI:
  - The counter counts valid samples since the previous spike sample. Spikes at sample indices 10 and 25 give ISI=15.
  - The counter saturates at 2^ISI_W-1 and does not wrap.
  - The first spike after reset produces no ISI. It only starts the count.
  - On every later spike the ISI is pushed to the FIFO on the same edge that registers spike. If the FIFO was empty, isi_valid rises in the same cycle as the spike pulse.
- FIFO:
  - A pop occurs when isi_valid && isi_ready. isi_data is the head entry; the output is first-word-fall-through.
  - Push while full and no pop: drop the new ISI, increment drop_cnt (saturating), keep existing contents.
  - Push and pop in the same cycle while full: both succeed, so occupancy is unchanged and nothing is dropped.
  - Push and pop in the same cycle while empty: the push is written and isi_valid rises next cycle. There is no bypass.
- Rate:
  - The window counter advances on each valid sample.
  - On the valid sample that completes 2^WIN_LOG2 samples:
    - rate <= window spike count, including a spike on that final sample.
    - rate_valid pulses for one cycle.
    - The window spike count restarts at 0.
  - rate holds its value between updates. Maximum rate is 2^(WIN_LOG2-1), so the count cannot overflow.
- Idle cycles with v_valid=0 change no state except FIFO pops.

Decomposition:
- Shared package qif_pkg holds:
  - signed voltage typedef volt_t (8-bit signed);
  - constants QIF_VPEAK=50, QIF_VRESET=-20, and the default THRESH and REARM.
- Natural sub-module: qif_isi_fifo. It is the synchronous FIFO with full, empty and drop signalling, parameterised by width and depth.
- Detector, ISI counter and rate window live in the top module.

Test Plan:
- Reset mid-stream: load the FIFO with 2 ISIs, pulse rst_n low -> isi_valid=0, drop_cnt=0, rate=0 immediately (asynchronously); the next spike produces no ISI.
- Threshold and hysteresis: v_in sequence -20, 10, 45, 60, 30, 45, -5, 41 (all valid) -> spikes on the 45 at index 2 and the 41 at index 7 only. One ISI=5 is pushed; isi_valid rises with the second spike pulse.
- Signed compare: v_in = 0xC8 (-56) while armed -> no spike; v_in = 0x32 (50) -> spike.
- FIFO full and drops: isi_ready=0, 6 spikes spaced 3 samples apart -> 5 ISIs generated, 4 stored (all 3), drop_cnt=1. Then isi_ready=1 -> 4 pops of 3, then isi_valid=0.
- Simultaneous push/pop while full: with the FIFO full and isi_ready=1, a spike occurs -> occupancy stays 4 and drop_cnt is unchanged.
- Rate window: WIN_LOG2=4, a spike every 4 samples, including one on sample 16 -> rate=4 with rate_valid pulsing once per 16 valid samples. ISI saturation: ISI_W=4 with a 20-sample gap -> ISI=15.
